// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the convolution-layer sequencer.
//   state_e  - sequencer FSM states
//   KSIZE_W  - width of the kernel-size config field
//   npass()  - number of output-channel passes for a given PE array width
package conv_pkg;

    localparam int KSIZE_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        WAIT,
        STORE,
        ADV,
        DONE
    } state_e;

    // ceil(out_ch / pe_cols)
    function automatic int unsigned npass(input int unsigned out_ch,
                                          input int unsigned pe_cols);
        return (out_ch + pe_cols - 1) / pe_cols;
    endfunction

endpackage

// File: rtl/conv_loop_cnt.sv
// conv_loop_cnt: row / output-channel-pass loop counters for conv_seq.
//   clk, rst     - clock, async active-high reset
//   clr_i        - zero all counters
//   adv_i        - step to the next row (wrapping into the next pass)
//   row_max_i    - last row index of a pass (R_OUT-1)
//   pass_max_i   - last pass index (NPASS-1)
//   row_o        - current output row
//   ch_base_o    - first output channel of the current pass
//   row_last_o   - current row is the last of the pass
//   last_o       - current row is the last row of the last pass
module conv_loop_cnt #(
    parameter int DIM_W   = 10,
    parameter int CH_W    = 10,
    parameter int PE_COLS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic [DIM_W-1:0] row_max_i,
    input  logic [CH_W-1:0]  pass_max_i,
    output logic [DIM_W-1:0] row_o,
    output logic [CH_W-1:0]  ch_base_o,
    output logic             row_last_o,
    output logic             last_o
);

    logic [DIM_W-1:0] row_q;
    logic [CH_W-1:0]  pass_q;
    logic [CH_W-1:0]  base_q;

    assign row_last_o = (row_q == row_max_i);
    assign last_o     = row_last_o && (pass_q == pass_max_i);
    assign row_o      = row_q;
    assign ch_base_o  = base_q;

    // base is kept as a running sum rather than pass*PE_COLS; wraps at CH_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q  <= '0;
            pass_q <= '0;
            base_q <= '0;
        end else if (clr_i) begin
            row_q  <= '0;
            pass_q <= '0;
            base_q <= '0;
        end else if (adv_i) begin
            if (row_last_o) begin
                row_q  <= '0;
                pass_q <= pass_q + CH_W'(1);
                base_q <= base_q + CH_W'(PE_COLS);
            end else begin
                row_q <= row_q + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_seq.sv
// conv_seq: convolution-layer sequencer. Walks a layer as output-channel
// passes x output rows; each row is fetch -> PE compute -> writeback.
//   clk, rst              - clock, async active-high reset
//   start                 - job start pulse (only honoured in IDLE)
//   cfg_rows/out_ch/ksize - layer config, latched on accepted start
//   buf_rd_req/row/ack    - input window fetch handshake
//   pe_start/ch_base/done - PE array launch pulse / pass base / completion
//   buf_wr_req/ack        - result writeback handshake
//   aybz_azby             - ping-pong buffer select, toggles per row
//   busy/done/err         - job status; err pulses with done on bad config
module conv_seq
    import conv_pkg::*;
#(
    parameter int DIM_W   = 10,
    parameter int CH_W    = 10,
    parameter int PE_COLS = 8,
    parameter int KMAX    = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DIM_W-1:0]   cfg_rows,
    input  logic [CH_W-1:0]    cfg_out_ch,
    input  logic [KSIZE_W-1:0] cfg_ksize,
    output logic               buf_rd_req,
    output logic [DIM_W-1:0]   buf_rd_row,
    input  logic               buf_rd_ack,
    output logic               pe_start,
    output logic [CH_W-1:0]    pe_ch_base,
    input  logic               pe_done,
    output logic               buf_wr_req,
    input  logic               buf_wr_ack,
    output logic               aybz_azby,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_e state_q, state_d;

    logic [DIM_W-1:0]   rows_q;
    logic [CH_W-1:0]    och_q;
    logic [KSIZE_W-1:0] ks_q;
    logic               bad_q;
    logic               aybz_q;

    logic               accept;
    logic               cfg_ok;
    logic [DIM_W-1:0]   row_max;
    logic [CH_W-1:0]    pass_max;
    logic               cnt_clr;
    logic               row_last;
    logic               last;

    assign accept = (state_q == IDLE) && start;

    // Legality is judged on the live inputs because they are latched on the
    // same edge that takes the IDLE branch.
    assign cfg_ok = cfg_ksize[0]
                 && (cfg_ksize <= KSIZE_W'(KMAX))
                 && (cfg_rows >= DIM_W'(cfg_ksize))
                 && (cfg_out_ch != '0);

    // Only meaningful for a legal latched config (rows >= ksize, out_ch >= 1)
    assign row_max  = rows_q - DIM_W'(ks_q);
    assign pass_max = CH_W'(npass(32'(och_q), PE_COLS) - 1);

    // Clearing on DONE leaves the row/base outputs at 0 while idle
    assign cnt_clr = accept || (state_q == DONE);

    conv_loop_cnt #(
        .DIM_W   (DIM_W),
        .CH_W    (CH_W),
        .PE_COLS (PE_COLS)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .adv_i      (state_q == ADV),
        .row_max_i  (row_max),
        .pass_max_i (pass_max),
        .row_o      (buf_rd_row),
        .ch_base_o  (pe_ch_base),
        .row_last_o (row_last),
        .last_o     (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)      state_d = cfg_ok ? LOAD : DONE;
            LOAD:    if (buf_rd_ack) state_d = FIRE;
            FIRE:                    state_d = WAIT;
            WAIT:    if (pe_done)    state_d = STORE;
            STORE:   if (buf_wr_ack) state_d = ADV;
            ADV:                     state_d = last ? DONE : LOAD;
            DONE:                    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rows_q  <= '0;
            och_q   <= '0;
            ks_q    <= '0;
            bad_q   <= 1'b0;
            aybz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rows_q <= cfg_rows;
                och_q  <= cfg_out_ch;
                ks_q   <= cfg_ksize;
                bad_q  <= !cfg_ok;
                aybz_q <= 1'b0;
            end else if (state_q == ADV) begin
                aybz_q <= !aybz_q;
            end
        end
    end

    // row_last is folded into last; kept visible for debug
    logic unused_ok;
    assign unused_ok = row_last;

    assign buf_rd_req = (state_q == LOAD);
    assign pe_start   = (state_q == FIRE);
    assign buf_wr_req = (state_q == STORE);
    assign aybz_azby  = aybz_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = (state_q == DONE) && bad_q;

endmodule

// File: tb/tb_conv_seq.sv
// tb_conv_seq: directed self-checking bench for conv_seq. Acts as buffer and
// PE controllers with configurable ack / pe_done delays.
module tb_conv_seq;
    localparam int DIM_W = 10, CH_W = 10, PE_COLS = 8, KMAX = 7;

    logic             clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [DIM_W-1:0] cfg_rows = '0;
    logic [CH_W-1:0]  cfg_out_ch = '0;
    logic [2:0]       cfg_ksize = '0;
    logic             buf_rd_req, pe_start, buf_wr_req, aybz_azby, busy, done, err;
    logic [DIM_W-1:0] buf_rd_row;
    logic [CH_W-1:0]  pe_ch_base;
    logic             buf_rd_ack = 1'b0, pe_done = 1'b0, buf_wr_ack = 1'b0;

    conv_seq #(.DIM_W(DIM_W), .CH_W(CH_W), .PE_COLS(PE_COLS), .KMAX(KMAX)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_rows(cfg_rows), .cfg_out_ch(cfg_out_ch), .cfg_ksize(cfg_ksize),
        .buf_rd_req(buf_rd_req), .buf_rd_row(buf_rd_row), .buf_rd_ack(buf_rd_ack),
        .pe_start(pe_start), .pe_ch_base(pe_ch_base), .pe_done(pe_done),
        .buf_wr_req(buf_wr_req), .buf_wr_ack(buf_wr_ack),
        .aybz_azby(aybz_azby), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int vec = 0, miscomp = 0;
    int pe_dly = 0, extra_at = 0;
    bit rand_en = 0, stray_en = 0;
    int rd_cnt, wr_cnt, pcnt;
    bit rd_act, rd_acked, wr_act, wr_acked, pend;
    int n_req, n_pe, n_wr, n_done, proto_err;
    int err_at_done, busy_at_done, cyc;
    int rd_rows[$], ayb_log[$], bases[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miscomp++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        n_req = 0; n_pe = 0; n_wr = 0; n_done = 0; proto_err = 0;
        rd_rows.delete(); ayb_log.delete(); bases.delete();
    endtask

    task automatic clr_resp();
        rd_act = 0; rd_acked = 0; wr_act = 0; wr_acked = 0; pend = 0;
        rd_cnt = 0; wr_cnt = 0; pcnt = 0;
        buf_rd_ack = 0; buf_wr_ack = 0; pe_done = 0;
    endtask

    // One clock: sample DUT 1 time unit after the edge, then drive responses.
    task automatic tick();
        @(posedge clk); #1;
        pe_done = 1'b0;
        if (pend) begin
            if (pcnt == 0) begin pe_done = 1'b1; pend = 0; end
            else pcnt--;
        end
        if (pe_start) begin
            n_pe++; bases.push_back(int'(pe_ch_base));
            pend = 1; pcnt = rand_en ? int'($urandom_range(0, 6)) : pe_dly;
        end
        if (buf_rd_req) begin
            if (rd_act && rd_acked) proto_err++;   // req held past accepted ack
            if (!rd_act) begin
                rd_act = 1; rd_acked = 0; n_req++;
                rd_rows.push_back(int'(buf_rd_row)); ayb_log.push_back(int'(aybz_azby));
                rd_cnt = rand_en ? int'($urandom_range(0, 6)) : 0;
            end
            buf_rd_ack = (rd_cnt == 0);
            if (rd_cnt != 0) rd_cnt--;
            if (buf_rd_ack) rd_acked = 1;
        end else begin
            if (rd_act && !rd_acked) proto_err++;  // req dropped before ack
            rd_act = 0; buf_rd_ack = 1'b0;
        end
        if (stray_en && buf_rd_req && !buf_rd_ack) pe_done = 1'b1;
        if (buf_wr_req) begin
            if (wr_act && wr_acked) proto_err++;
            if (!wr_act) begin
                wr_act = 1; wr_acked = 0;
                wr_cnt = rand_en ? int'($urandom_range(0, 6)) : 0;
            end
            buf_wr_ack = (wr_cnt == 0);
            if (wr_cnt != 0) wr_cnt--;
            if (buf_wr_ack) begin wr_acked = 1; n_wr++; end
        end else begin
            if (wr_act && !wr_acked) proto_err++;
            wr_act = 0; buf_wr_ack = 1'b0;
        end
        if (done) n_done++;
    endtask

    // cyc = edges from the start-sampling edge up to the sample showing done
    task automatic run_job(input int rows, input int och, input int ks);
        clr_stats();
        cfg_rows = DIM_W'(rows); cfg_out_ch = CH_W'(och); cfg_ksize = 3'(ks);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 2000) begin
            start = (cyc == extra_at);
            if (start) cfg_rows = DIM_W'(9);
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        err_at_done = int'(err); busy_at_done = int'(busy);
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {25'd0, buf_rd_req, pe_start, buf_wr_req, aybz_azby, busy, done, err}, 32'd0);
        chk({tag, "_row"}, 32'(buf_rd_row), 32'd0);
        chk({tag, "_base"}, 32'(pe_ch_base), 32'd0);
    endtask

    initial begin
        clr_stats(); clr_resp();
        rst = 1'b1;
        tick(); tick();
        chk_idle("reset_outs");
        rst = 1'b0;
        tick();
        chk_idle("idle_outs");

        // 5 rows, k=3 -> R_OUT=3, 8 channels -> 1 pass
        run_job(5, 8, 3);
        chk("t1_done_cyc", 32'(cyc), 32'd16);
        chk("t1_err", 32'(err_at_done), 32'd0);
        chk("t1_busy_at_done", 32'(busy_at_done), 32'd1);
        chk("t1_nreq", 32'(n_req), 32'd3);
        chk("t1_npe", 32'(n_pe), 32'd3);
        chk("t1_nwr", 32'(n_wr), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_row%0d", i), 32'(rd_rows[i]), 32'(i));
            chk($sformatf("t1_ayb%0d", i), 32'(ayb_log[i]), 32'(i % 2));
            chk($sformatf("t1_base%0d", i), 32'(bases[i]), 32'd0);
        end
        chk("t1_ayb_final", 32'(aybz_azby), 32'd1);
        chk("t1_proto", 32'(proto_err), 32'd0);
        tick();
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_done_after", 32'(done), 32'd0);

        // 3 rows, k=3 -> 1 row per pass, 20 channels -> 3 passes
        run_job(3, 20, 3);
        chk("t2_done_cyc", 32'(cyc), 32'd16);
        chk("t2_npe", 32'(n_pe), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_base%0d", i), 32'(bases[i]), 32'(8 * i));
            chk($sformatf("t2_row%0d", i), 32'(rd_rows[i]), 32'd0);
        end
        tick();

        // illegal configs: even k, rows < k, zero channels
        run_job(5, 8, 4);
        chk("t3a_done_cyc", 32'(cyc), 32'd1);
        chk("t3a_err", 32'(err_at_done), 32'd1);
        chk("t3a_activity", 32'(n_req + n_pe + n_wr), 32'd0);
        tick();
        run_job(2, 8, 3);
        chk("t3b_done_cyc", 32'(cyc), 32'd1);
        chk("t3b_err", 32'(err_at_done), 32'd1);
        chk("t3b_activity", 32'(n_req + n_pe + n_wr), 32'd0);
        tick();
        run_job(5, 0, 3);
        chk("t3c_err", 32'(err_at_done), 32'd1);
        chk("t3c_activity", 32'(n_req + n_pe + n_wr), 32'd0);
        tick();
        chk("t3_busy_after", 32'(busy), 32'd0);

        // random delays, stray pe_done in LOAD, extra start mid-job
        rand_en = 1; stray_en = 1; extra_at = 7;
        run_job(6, 1, 1);
        extra_at = 0;
        chk("t4_err", 32'(err_at_done), 32'd0);
        chk("t4_nwr", 32'(n_wr), 32'd6);
        chk("t4_npe", 32'(n_pe), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t4_row%0d", i), 32'(rd_rows[i]), 32'(i));
        chk("t4_proto", 32'(proto_err), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("t4_ndone", 32'(n_done), 32'd1);
        chk("t4_nreq_after", 32'(n_req), 32'd6);
        chk("t4_busy_after", 32'(busy), 32'd0);
        rand_en = 0; stray_en = 0;

        // reset during WAIT of the second row, then a clean job
        pe_dly = 5;
        clr_stats();
        cfg_rows = 10'd5; cfg_out_ch = 10'd8; cfg_ksize = 3'd3;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 100 && n_pe < 2; i++) tick();
        tick();
        chk("t5_busy_in_wait", 32'(busy), 32'd1);
        chk("t5_ayb_in_wait", 32'(aybz_azby), 32'd1);
        rst = 1'b1; #1;
        chk_idle("t5_reset");
        clr_resp(); pe_dly = 0;
        tick();
        rst = 1'b0;
        tick();
        run_job(5, 8, 3);
        chk("t5_done_cyc", 32'(cyc), 32'd16);
        chk("t5_ndone", 32'(n_done), 32'd1);
        chk("t5_err", 32'(err_at_done), 32'd0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t5_row%0d", i), 32'(rd_rows[i]), 32'(i));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
        $finish;
    end
endmodule
